// File: rtl/alu_seq_pkg.sv
// Shared state encoding, status codes and response byte mux for the ALU frame sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ALU,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_t;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ALU_ERR = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;
  localparam logic [7:0] ST_BAD_OP  = 8'hE3;

  localparam logic [1:0] LAST_BYTE_IDX = 2'd2;

  // Response order on the wire: status, result high byte, result low byte.
  function automatic logic [7:0] resp_byte(input logic [1:0]  idx,
                                           input logic [7:0]  status,
                                           input logic [15:0] result);
    logic [7:0] b;
    case (idx)
      2'd0:    b = status;
      2'd1:    b = result[15:8];
      default: b = result[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Saturating cycle counter that flags the ALU_TIMEOUT-th enabled cycle since the last clear.
module alu_watchdog #(
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LAST_CNT = 8'(ALU_TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // r_cnt holds the number of enabled cycles already spent, so this fires in the last allowed one.
  assign o_expired = i_en && (r_cnt >= LAST_CNT);

endmodule

// File: rtl/alu_frame_sequencer.sv
// Runs one command frame through the ALU and returns a 3-byte status/result response to the UART.
module alu_frame_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NUM_OPS     = 8,
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [7:0]  operation,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_error,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_dropped,
  output logic [7:0]  last_status,
  output state_t      dbg_state
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_alu_op, r_alu_a, r_alu_b;
  logic [7:0]  w_alu_op_nxt, w_alu_a_nxt, w_alu_b_nxt;
  logic        r_alu_start, w_alu_start_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_tx_start, w_tx_start_nxt;
  logic        r_busy, r_frame_dropped;
  logic [7:0]  r_last_status, w_last_status_nxt;
  logic [7:0]  r_status, w_status_nxt;
  logic [15:0] r_result, w_result_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        w_wd_clr, w_wd_en, w_expired, w_op_valid;

  assign w_op_valid = ({24'd0, operation} < NUM_OPS);

  alu_watchdog #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_watchdog (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (w_wd_clr),
    .i_en      (w_en_wait()),
    .o_expired (w_expired)
  );

  function automatic logic w_en_wait();
    return w_wd_en;
  endfunction

  // Transmitter handshake: tx_start is a one-cycle request issued only after a cycle with
  // tx_busy low; the byte counts as accepted once tx_busy rises and finished once it falls,
  // and tx_data is only rewritten in TX_LOAD so it holds for that whole window.
  always_comb begin
    w_state_nxt       = r_state;
    w_alu_op_nxt      = r_alu_op;
    w_alu_a_nxt       = r_alu_a;
    w_alu_b_nxt       = r_alu_b;
    w_alu_start_nxt   = 1'b0;
    w_tx_data_nxt     = r_tx_data;
    w_tx_start_nxt    = 1'b0;
    w_last_status_nxt = r_last_status;
    w_status_nxt      = r_status;
    w_result_nxt      = r_result;
    w_idx_nxt         = r_idx;
    w_wd_clr          = 1'b0;
    w_wd_en           = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_valid) begin
          w_alu_op_nxt = operation;
          w_alu_a_nxt  = data_a;
          w_alu_b_nxt  = data_b;
          w_idx_nxt    = 2'd0;
          if (w_op_valid) begin
            w_alu_start_nxt = 1'b1;
            w_state_nxt     = ISSUE;
          end else begin
            w_status_nxt = ST_BAD_OP;
            w_result_nxt = 16'h0000;
            w_state_nxt  = TX_LOAD;
          end
        end
      end
      ISSUE: begin
        w_wd_clr    = 1'b1;
        w_state_nxt = WAIT_ALU;
      end
      WAIT_ALU: begin
        w_wd_en = 1'b1;
        if (alu_done) begin
          w_result_nxt = alu_result;
          w_status_nxt = alu_error ? ST_ALU_ERR : ST_OK;
          w_state_nxt  = TX_LOAD;
        end else if (w_expired) begin
          w_result_nxt = 16'h0000;
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = TX_LOAD;
        end
      end
      TX_LOAD: begin
        w_tx_data_nxt = resp_byte(r_idx, r_status, r_result);
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (tx_busy) w_state_nxt = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          if (r_idx == LAST_BYTE_IDX) begin
            w_last_status_nxt = r_status;
            w_state_nxt       = IDLE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = TX_LOAD;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_alu_op        <= '0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_start     <= 1'b0;
      r_tx_data       <= '0;
      r_tx_start      <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_dropped <= 1'b0;
      r_last_status   <= '0;
      r_status        <= '0;
      r_result        <= '0;
      r_idx           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_alu_op        <= w_alu_op_nxt;
      r_alu_a         <= w_alu_a_nxt;
      r_alu_b         <= w_alu_b_nxt;
      r_alu_start     <= w_alu_start_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_tx_start      <= w_tx_start_nxt;
      r_busy          <= (w_state_nxt != IDLE);
      r_frame_dropped <= frame_valid && (r_state != IDLE);
      r_last_status   <= w_last_status_nxt;
      r_status        <= w_status_nxt;
      r_result        <= w_result_nxt;
      r_idx           <= w_idx_nxt;
    end
  end

  assign alu_op        = r_alu_op;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_start     = r_alu_start;
  assign tx_data       = r_tx_data;
  assign tx_start      = r_tx_start;
  assign busy          = r_busy;
  assign frame_dropped = r_frame_dropped;
  assign last_status   = r_last_status;
  assign dbg_state     = r_state;

endmodule
